mm_operand_loader: RTL and testbench
====================================

Name: mm_operand_loader

Overview:
- Input stage directly upstream of the matrix-multiply engine.
- Accepts a serial stream of matrix elements over a valid/ready handshake: first all of matrix A, then all of matrix B, each in row-major order.
- Buffers both DIM x DIM operands and presents them in parallel to the multiplier through a second valid/ready handshake.
- Sits between the stimulus source (testbench driver or host interface) and the multiply core.

Parameters:
- DATA_W, 16, width of one matrix element in bits; unsigned, opaque to this block.
- DIM, 3, matrix dimension; each operand holds DIM*DIM elements; legal range 2..8.
- CNT_W, 8, width of the completed-handoff counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream element valid.
- in_ready  output  1  loader can accept an element.
- in_data  input  DATA_W  element value.
- in_sof  input  1  start-of-frame marker, meant to mark A[0,0]; used only with the optional feature.
- mat_valid  output  1  both operands buffered and stable.
- mat_ready  input  1  multiplier accepts the operand pair.
- mat_a  output  DIM*DIM*DATA_W  matrix A, flattened; element (r,c) at bits [(r*DIM+c)*DATA_W +: DATA_W].
- mat_b  output  DIM*DIM*DATA_W  matrix B, same packing.
- busy  output  1  high in LOAD_B, or in LOAD_A with idx != 0.
- matrix_count  output  CNT_W  number of completed mat handshakes.
- err  output  1  one-cycle framing-error pulse (optional feature).

Behaviour:
- Reset (rst_n low at a rising edge):
  - State = LOAD_A, idx = 0.
  - mat_valid = 0, mat_a = 0, mat_b = 0, matrix_count = 0, err = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-load or while in PRESENT discards all buffered data with no handoff.
- Accept condition: an input beat is accepted only when in_valid && in_ready. in_valid while in_ready is low is ignored; the upstream must hold the beat.
- LOAD_A:
  - in_ready = 1.
  - Accepted beat is written to A slot idx, then idx increments.
  - On accepting idx == DIM*DIM-1: idx goes to 0 and state goes to LOAD_B.
- LOAD_B:
  - in_ready = 1.
  - Accepted beat is written to B slot idx, then idx increments.
  - On accepting the last element: idx goes to 0, state goes to PRESENT, and mat_valid = 1 in the next cycle.
  - Latency: 1 cycle from acceptance of the final B beat to mat_valid.
- PRESENT:
  - in_ready = 0, including the cycle of the mat handshake; there is no bypass.
  - mat_valid is held and mat_a / mat_b stay stable until mat_ready is sampled high.
  - On mat_valid && mat_ready: mat_valid = 0 next cycle, matrix_count increments (wraps modulo 2^CNT_W), state goes to LOAD_A, and in_ready = 1 next cycle.
- mat_a / mat_b keep their last values after the handoff and are overwritten slot by slot during the next load.
- Minimum frame period: 2*DIM*DIM + 1 cycles with a continuous upstream and mat_ready tied high.
- in_ready and mat_valid are driven directly from state registers, not from combinational paths on in_valid or mat_ready.

Optional Feature:
- Macro: MM_LOADER_SOF_CHECK_EN.
- Defined:
  - In LOAD_A with idx == 0, an accepted beat with in_sof = 0 is dropped, idx stays 0, and err pulses high for 1 cycle.
  - An accepted beat with in_sof = 1 while in LOAD_A (idx != 0) or in LOAD_B is a resync: err pulses, the partial frame is abandoned, and the beat is stored as A[0]. State becomes LOAD_A with idx = 1.
  - matrix_count is unaffected by both cases.
- Undefined: in_sof is ignored and err is tied to 0.

Test Plan (DIM=2, DATA_W=16):
- Reset, then stream A = 1,2,3,4 and B = 5,6,7,8 back-to-back with mat_ready = 1 -> mat_valid rises 1 cycle after the beat carrying 8; mat_a = {4,3,2,1}, mat_b = {8,7,6,5} (MSB..LSB); mat_valid lasts 1 cycle; matrix_count = 1; in_ready high again the following cycle.
- Same frame with mat_ready = 0 for 5 cycles -> mat_valid and both operands stable for 6 cycles; in_ready = 0 throughout; in_valid pulses during this window are not accepted; matrix_count stays 0 until the handshake.
- in_valid toggled every other cycle across a full frame -> exactly 8 beats accepted in order; result matches scenario 1.
- Assert rst_n low after 5 accepted beats -> mat_valid never rises; the next full frame loads cleanly with idx starting at 0.
- 256 consecutive frames with CNT_W=8 -> matrix_count wraps to 0.
- With MM_LOADER_SOF_CHECK_EN: first beat sent with in_sof = 0 -> err pulses and the beat is dropped. A resync in_sof = 1 sent as the 3rd beat of B -> err pulses and loading restarts at A with that beat as A[0]. Without the macro, err stays 0 in both cases.

Source files
------------

// File: rtl/mm_operand_loader.sv
// mm_operand_loader: buffers serial A then B elements and hands both operands to the multiplier in parallel.
// Optional SOF framing check is compiled in with `define MM_LOADER_SOF_CHECK_EN.
module mm_operand_loader #(
   parameter int DATA_W = 16,
   parameter int DIM    = 3,
   parameter int CNT_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      in_sof,
   output logic                      mat_valid,
   input  logic                      mat_ready,
   output logic [DIM*DIM*DATA_W-1:0] mat_a,
   output logic [DIM*DIM*DATA_W-1:0] mat_b,
   output logic                      busy,
   output logic [CNT_W-1:0]          matrix_count,
   output logic                      err
);
   localparam int N     = DIM * DIM;
   localparam int IDX_W = $clog2(N);

   typedef enum logic [1:0] {LOAD_A, LOAD_B, PRESENT} state_t;

   state_t            state, state_next;
   logic [IDX_W-1:0]  idx, idx_next, wr_idx;
   logic              accept, last, wr_a, wr_b, drop, resync;

   assign accept    = in_valid && in_ready;
   assign last      = idx == IDX_W'(N - 1);
   assign in_ready  = state != PRESENT;
   assign mat_valid = state == PRESENT;
   assign busy      = state == LOAD_B || (state == LOAD_A && idx != '0);
   assign wr_idx    = resync ? '0 : idx;

`ifdef MM_LOADER_SOF_CHECK_EN
   assign drop   = accept && state == LOAD_A && idx == '0 && !in_sof;
   assign resync = accept && in_sof && busy;
`else
   logic unused_sof;
   assign unused_sof = in_sof;
   assign drop       = 1'b0;
   assign resync     = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= LOAD_A;
      else        state <= state_next;
   end

   // next state, slot index and operand write enables
   always_comb begin
      state_next = state;
      idx_next   = idx;
      wr_a       = 1'b0;
      wr_b       = 1'b0;
      if (resync) begin
         state_next = LOAD_A;
         idx_next   = IDX_W'(1);
         wr_a       = 1'b1;
      end else if (!drop) begin
         case (state)
            LOAD_A: if (accept) begin
               wr_a       = 1'b1;
               idx_next   = last ? '0 : idx + IDX_W'(1);
               state_next = last ? LOAD_B : LOAD_A;
            end
            LOAD_B: if (accept) begin
               wr_b       = 1'b1;
               idx_next   = last ? '0 : idx + IDX_W'(1);
               state_next = last ? PRESENT : LOAD_B;
            end
            default: state_next = mat_ready ? LOAD_A : PRESENT;
         endcase
      end
   end

   // operand buffers, index, handoff counter and error pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx          <= '0;
         mat_a        <= '0;
         mat_b        <= '0;
         matrix_count <= '0;
         err          <= 1'b0;
      end else begin
         idx <= idx_next;
         err <= drop || resync;
         if (wr_a) mat_a[int'(wr_idx)*DATA_W +: DATA_W] <= in_data;
         if (wr_b) mat_b[int'(wr_idx)*DATA_W +: DATA_W] <= in_data;
         if (mat_valid && mat_ready) matrix_count <= matrix_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_mm_operand_loader.sv
// tb_mm_operand_loader: directed self-checking bench for mm_operand_loader with DIM=2, DATA_W=16.
module tb_mm_operand_loader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_sof = 1'b0;
   logic        mat_valid;
   logic        mat_ready = 1'b1;
   logic [63:0] mat_a, mat_b;
   logic        busy;
   logic [7:0]  matrix_count;
   logic        err;
   int          errors = 0;
   int          checks = 0;

   mm_operand_loader #(.DATA_W(16), .DIM(2), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sof(in_sof), .mat_valid(mat_valid), .mat_ready(mat_ready),
      .mat_a(mat_a), .mat_b(mat_b), .busy(busy), .matrix_count(matrix_count), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic stream(input int first);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(first + i);
         in_sof   = i == 0;
         tick();
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic beat(input logic [15:0] d, input logic s);
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("beat_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = s;
      tick();
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mat_valid", mat_valid, 0);
      chk("rst_mat_a", mat_a, 0);
      chk("rst_mat_b", mat_b, 0);
      chk("rst_count", matrix_count, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);

      stream(1);
      chk("s1_valid", mat_valid, 1);
      chk("s1_in_ready", in_ready, 0);
      chk("s1_mat_a", mat_a, 64'h0004_0003_0002_0001);
      chk("s1_mat_b", mat_b, 64'h0008_0007_0006_0005);
      chk("s1_count_pre", matrix_count, 0);
      tick();
      chk("s1_valid_drop", mat_valid, 0);
      chk("s1_ready_back", in_ready, 1);
      chk("s1_count", matrix_count, 1);

      mat_ready = 1'b0;
      stream(9);
      chk("s2_valid", mat_valid, 1);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_data  = 16'hdead;
         tick();
         chk("s2_hold_valid", mat_valid, 1);
         chk("s2_hold_ready", in_ready, 0);
         chk("s2_hold_a", mat_a, 64'h000c_000b_000a_0009);
         chk("s2_hold_b", mat_b, 64'h0010_000f_000e_000d);
         chk("s2_hold_count", matrix_count, 1);
      end
      in_valid  = 1'b0;
      mat_ready = 1'b1;
      tick();
      chk("s2_valid_drop", mat_valid, 0);
      chk("s2_count", matrix_count, 2);
      chk("s2_a_kept", mat_a, 64'h000c_000b_000a_0009);

      for (int i = 0; i < 15; i++) begin
         in_valid = !i[0];
         in_data  = 16'(1 + i / 2);
         in_sof   = i == 0;
         tick();
         if (i == 13) chk("s3_not_yet", mat_valid, 0);
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      chk("s3_valid", mat_valid, 1);
      chk("s3_mat_a", mat_a, 64'h0004_0003_0002_0001);
      chk("s3_mat_b", mat_b, 64'h0008_0007_0006_0005);
      tick();
      chk("s3_count", matrix_count, 3);

      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(31 + i);
         in_sof   = i == 0;
         tick();
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      chk("s4_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("s4_rst_a", mat_a, 0);
      chk("s4_rst_count", matrix_count, 0);
      chk("s4_rst_busy", busy, 0);
      tick();
      tick();
      chk("s4_no_valid", mat_valid, 0);
      stream(41);
      chk("s4_valid", mat_valid, 1);
      chk("s4_mat_a", mat_a, 64'h002c_002b_002a_0029);
      chk("s4_mat_b", mat_b, 64'h0030_002f_002e_002d);
      tick();
      chk("s4_count", matrix_count, 1);

      for (int f = 0; f < 254; f++) begin
         stream(f);
         tick();
      end
      chk("s5_count_255", matrix_count, 255);
      stream(100);
      tick();
      chk("s5_wrap", matrix_count, 0);

      beat(16'h0099, 1'b0);
`ifdef MM_LOADER_SOF_CHECK_EN
      chk("s6_drop_err", err, 1);
      tick();
      chk("s6_err_pulse", err, 0);
      chk("s6_drop_idx", busy, 0);
`else
      chk("s6_drop_err", err, 0);
`endif
      for (int i = 1; i <= 6; i++) beat(16'(i), i == 1);
      beat(16'h0077, 1'b1);
`ifdef MM_LOADER_SOF_CHECK_EN
      chk("s6_resync_err", err, 1);
      chk("s6_resync_busy", busy, 1);
      for (int i = 0; i < 7; i++) beat(16'(16'h0078 + i), 1'b0);
      chk("s6_valid", mat_valid, 1);
      chk("s6_mat_a", mat_a, 64'h007a_0079_0078_0077);
      chk("s6_mat_b", mat_b, 64'h007e_007d_007c_007b);
`else
      chk("s6_resync_err", err, 0);
      chk("s6_valid", mat_valid, 1);
      chk("s6_mat_a", mat_a, 64'h0003_0002_0001_0099);
      chk("s6_mat_b", mat_b, 64'h0077_0006_0005_0004);
`endif
      tick();
      chk("s6_count", matrix_count, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
